// File: rtl/spi_master_multi_if.sv
// Bundle between the local controller and the SPI pins for spi_master_multi.
// The master modport is the SPI master's view. The slave modport is the opposite side:
// the controller and the off-chip device.
interface spi_master_multi_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_SS = 4
);
  localparam int unsigned SSW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;

  logic             start;
  logic             cpol;
  logic             cpha;
  logic [SSW-1:0]   ss_sel;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] data_out;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic [NUM_SS-1:0] ss_n;

  modport master (
    input  start, cpol, cpha, ss_sel, data_in, miso,
    output busy, done, data_out, sclk, mosi, ss_n
  );

  modport slave (
    output start, cpol, cpha, ss_sel, data_in, miso,
    input  busy, done, data_out, sclk, mosi, ss_n
  );
endinterface

// File: rtl/spi_master_multi.sv
// Parametrised SPI master: one full-duplex frame per accepted start, any CPOL/CPHA mode,
// programmable SCLK half-period, configurable width and bit order, NUM_SS active-low selects.
module spi_master_multi #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_SS    = 4,
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          LSB_FIRST = 1'b0
) (
  input  logic clk,
  input  logic rst,
  spi_master_multi_if.master bus
);
  localparam int unsigned SSW = (NUM_SS > 1) ? $clog2(NUM_SS) : 1;
  localparam int unsigned DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned TW  = $clog2(2 * WIDTH);

  typedef enum logic [2:0] {IDLE, SETUP, XFER, HOLD, GAP} state_t;

  state_t           state;
  logic [DW-1:0]    div_cnt;
  logic [TW-1:0]    tog_cnt;
  logic             cpha_q;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic             tick;
  logic             leading;
  logic             last_tog;

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? v[0] : v[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] shift_tx(input logic [WIDTH-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [WIDTH-1:0] shift_rx(input logic [WIDTH-1:0] v, input logic b);
    return LSB_FIRST ? {b, v[WIDTH-1:1]} : {v[WIDTH-2:0], b};
  endfunction

  // Out-of-range selects decode to all lines high.
  function automatic logic [NUM_SS-1:0] ss_decode(input logic [SSW-1:0] sel);
    logic [NUM_SS-1:0] v;
    v = '1;
    for (int unsigned i = 0; i < NUM_SS; i++) begin
      if (32'(sel) == i) v[i] = 1'b0;
    end
    return v;
  endfunction

  // Half-period tick and position of the current SCLK toggle within the frame.
  always_comb begin
    tick     = (state != IDLE) && (div_cnt == DW'(CLK_DIV - 1));
    leading  = ~tog_cnt[0];
    last_tog = (tog_cnt == TW'(2 * WIDTH - 1));
  end

  // Frame sequencer, divider, shift registers and all registered pin/handshake outputs.
  // tx_sr always holds the bits not yet presented on mosi. In mode cpha=0 the first bit is
  // presented at start, so tx_sr is loaded pre-shifted. Both modes then see exactly WIDTH
  // presentations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      div_cnt      <= '0;
      tog_cnt      <= '0;
      cpha_q       <= 1'b0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      bus.sclk     <= 1'b0;
      bus.mosi     <= 1'b0;
      bus.ss_n     <= '1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.data_out <= '0;
    end else begin
      bus.done <= 1'b0;

      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + 1'b1;

      case (state)
        IDLE: begin
          bus.sclk <= bus.cpol;
          bus.ss_n <= '1;
          if (bus.start) begin
            cpha_q   <= bus.cpha;
            rx_sr    <= '0;
            tog_cnt  <= '0;
            bus.busy <= 1'b1;
            bus.ss_n <= ss_decode(bus.ss_sel);
            if (!bus.cpha) begin
              bus.mosi <= first_bit(bus.data_in);
              tx_sr    <= shift_tx(bus.data_in);
            end else begin
              tx_sr    <= bus.data_in;
            end
            state <= SETUP;
          end
        end

        SETUP: begin
          if (tick) state <= XFER;
        end

        XFER: begin
          if (tick) begin
            bus.sclk <= ~bus.sclk;
            tog_cnt  <= tog_cnt + 1'b1;
            if (leading) begin
              if (cpha_q) begin
                bus.mosi <= first_bit(tx_sr);
                tx_sr    <= shift_tx(tx_sr);
              end else begin
                rx_sr <= shift_rx(rx_sr, bus.miso);
              end
            end else begin
              if (cpha_q) begin
                rx_sr <= shift_rx(rx_sr, bus.miso);
              end else if (!last_tog) begin
                bus.mosi <= first_bit(tx_sr);
                tx_sr    <= shift_tx(tx_sr);
              end
            end
            if (last_tog) state <= HOLD;
          end
        end

        HOLD: begin
          if (tick) begin
            bus.ss_n <= '1;
            state    <= GAP;
          end
        end

        GAP: begin
          if (tick) begin
            bus.data_out <= rx_sr;
            bus.done     <= 1'b1;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_multi.sv
// Testbench for spi_master_multi. It drives two instances: the default configuration, and
// NUM_SS=3 with LSB-first order and CLK_DIV=1. A behavioural SPI slave drives each instance.
// A scoreboard queue holds the expected frame results, and a monitor checks them on done.
module tb_spi_master_multi;
  localparam int unsigned W   = 8;
  localparam int unsigned CD0 = 4;
  localparam int unsigned CD1 = 1;
  localparam int unsigned NS0 = 4;
  localparam int unsigned NS1 = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  spi_master_multi_if #(.WIDTH(W), .NUM_SS(NS0)) ifa ();
  spi_master_multi_if #(.WIDTH(W), .NUM_SS(NS1)) ifb ();

  spi_master_multi #(.WIDTH(W), .NUM_SS(NS0), .CLK_DIV(CD0), .LSB_FIRST(1'b0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
  spi_master_multi #(.WIDTH(W), .NUM_SS(NS1), .CLK_DIV(CD1), .LSB_FIRST(1'b1))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

  logic [1:0]   start_v = '0, cpol_v = '0, cpha_v = '0, loop_v = '0, miso_v = '0;
  logic [1:0]   slv_cpol = '0, slv_cpha = '0;
  logic [1:0]   busy_v, done_v, sclk_v, mosi_v;
  logic [1:0]   sel_v   [2];
  logic [W-1:0] din_v   [2];
  logic [W-1:0] dout_v  [2];
  logic [3:0]   ss_v    [2];
  logic [W-1:0] slv_reply [2];
  logic [W-1:0] slv_cap   [2];

  assign ifa.start = start_v[0];  assign ifb.start = start_v[1];
  assign ifa.cpol  = cpol_v[0];   assign ifb.cpol  = cpol_v[1];
  assign ifa.cpha  = cpha_v[0];   assign ifb.cpha  = cpha_v[1];
  assign ifa.ss_sel  = sel_v[0];  assign ifb.ss_sel  = sel_v[1];
  assign ifa.data_in = din_v[0];  assign ifb.data_in = din_v[1];
  assign ifa.miso = loop_v[0] ? ifa.mosi : miso_v[0];
  assign ifb.miso = loop_v[1] ? ifb.mosi : miso_v[1];
  assign busy_v = {ifb.busy, ifa.busy};
  assign done_v = {ifb.done, ifa.done};
  assign sclk_v = {ifb.sclk, ifa.sclk};
  assign mosi_v = {ifb.mosi, ifa.mosi};
  assign dout_v[0] = ifa.data_out;  assign dout_v[1] = ifb.data_out;
  assign ss_v[0] = ifa.ss_n;        assign ss_v[1] = {1'b1, ifb.ss_n};

  typedef struct {
    int          inst;
    logic [W-1:0] rx;
    logic [W-1:0] tx;
    logic [3:0]  ss;
    int unsigned lat;
    int unsigned t0;
    logic        cpol;
    bit          sel_ok;
  } exp_t;

  exp_t sbq[$];

  function automatic int unsigned cd_of(input int i);
    return (i == 0) ? CD0 : CD1;
  endfunction

  function automatic int unsigned ns_of(input int i);
    return (i == 0) ? NS0 : NS1;
  endfunction

  // Bit position carried by the k-th serial bit of a frame.
  function automatic int unsigned pos(input int i, input int unsigned k);
    return (i != 0) ? k : (W - 1 - k);
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", n, act, exp, $time);
    end
  endtask

  function automatic exp_t make_exp(input int i, input logic pol, input logic [1:0] sel,
                                    input logic [W-1:0] d, input logic loop,
                                    input logic [W-1:0] reply, input int unsigned t0);
    exp_t e;
    e.inst   = i;
    e.sel_ok = (int'(sel) < int'(ns_of(i)));
    e.tx     = d;
    e.rx     = loop ? d : (e.sel_ok ? reply : '0);
    e.ss     = e.sel_ok ? ~(4'b0001 << sel) : 4'hF;
    e.lat    = (2 * W + 3) * cd_of(i);
    e.t0     = t0;
    e.cpol   = pol;
    return e;
  endfunction

  // Set the frame inputs, let the idle clock settle, then pulse start for one cycle.
  task automatic launch(input int i, input logic pol, input logic pha, input logic [1:0] sel,
                        input logic [W-1:0] d, input logic loop, input logic [W-1:0] reply,
                        output int unsigned t0);
    @(negedge clk);
    cpol_v[i] = pol;  cpha_v[i] = pha;  sel_v[i] = sel;  din_v[i] = d;
    loop_v[i] = loop; slv_reply[i] = reply; slv_cpol[i] = pol; slv_cpha[i] = pha;
    @(negedge clk);
    chk("sclk_idle", 32'(sclk_v[i]), 32'(pol));
    start_v[i] = 1'b1;
    t0 = cyc + 1;
    sbq.push_back(make_exp(i, pol, sel, d, loop, reply, t0));
    @(negedge clk);
    start_v[i] = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (sbq.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("done_timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
    @(negedge clk);
  endtask

  task automatic rand_frame(input int i);
    int unsigned t0;
    launch(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           W'($urandom), 1'($urandom_range(0, 3) == 0), W'($urandom), t0);
    drain();
  endtask

  // Behavioural SPI slave. It shifts slv_reply out and captures mosi at the mode's sample
  // edges. SCLK edges are observed half a clock after the master produces them.
  task automatic slave(input int i);
    logic ps, psel, sel, lead;
    int unsigned ntx, nrx;
    logic [W-1:0] cap;
    ps = 1'b0; psel = 1'b0; ntx = 0; nrx = 0; cap = '0;
    forever begin
      @(negedge clk);
      sel = (ss_v[i] != 4'hF);
      if (sel && !psel) begin
        cap = '0; nrx = 0; ntx = 0;
        if (!slv_cpha[i]) begin
          miso_v[i] = slv_reply[i][pos(i, 0)];
          ntx = 1;
        end
      end else if (sel && sclk_v[i] != ps) begin
        lead = (sclk_v[i] != slv_cpol[i]);
        if (lead == !slv_cpha[i]) begin
          if (nrx < W) cap[pos(i, nrx)] = mosi_v[i];
          nrx++;
        end else if (ntx < W) begin
          miso_v[i] = slv_reply[i][pos(i, ntx)];
          ntx++;
        end
      end else if (!sel && psel) begin
        slv_cap[i] = cap;
        miso_v[i]  = 1'b0;
      end
      psel = sel;
      ps   = sclk_v[i];
    end
  endtask

  // Monitor: counts SCLK toggles and accumulates the selects seen while busy.
  // On each done it pops the oldest expectation and checks it.
  task automatic monitor(input int i);
    exp_t e;
    int unsigned tog;
    logic [3:0] ssand;
    logic ps;
    tog = 0; ssand = 4'hF; ps = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        tog = 0; ssand = 4'hF;
      end else begin
        if (busy_v[i]) begin
          if (sclk_v[i] != ps) tog++;
          ssand &= ss_v[i];
        end
        if (done_v[i]) begin
          if (sbq.size() == 0) begin
            chk("spurious_done", 32'(i), 32'hFFFF_FFFF);
          end else begin
            e = sbq.pop_front();
            chk("done_inst", 32'(i), 32'(e.inst));
            chk("data_out", 32'(dout_v[i]), 32'(e.rx));
            chk("latency", cyc - e.t0, e.lat);
            if (e.sel_ok) chk("slave_rx", 32'(slv_cap[i]), 32'(e.tx));
            chk("ss_n_frame", 32'(ssand), 32'(e.ss));
            chk("sclk_toggles", tog, 2 * W);
            chk("sclk_end", 32'(sclk_v[i]), 32'(e.cpol));
            chk("busy_at_done", 32'(busy_v[i]), 32'd0);
          end
          tog = 0; ssand = 4'hF;
        end
      end
      ps = sclk_v[i];
    end
  endtask

  initial fork
    slave(0);
    slave(1);
    monitor(0);
    monitor(1);
  join_none

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned t0;
    logic [W-1:0] d1, d2, r1, r2;
    sel_v[0] = '0; sel_v[1] = '0; din_v[0] = '0; din_v[1] = '0;
    slv_reply[0] = '0; slv_reply[1] = '0; slv_cap[0] = '0; slv_cap[1] = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy_v), 32'd0);
    chk("rst_done", 32'(done_v), 32'd0);
    chk("rst_sclk", 32'(sclk_v), 32'd0);
    chk("rst_mosi", 32'(mosi_v), 32'd0);
    chk("rst_ss_a", 32'(ss_v[0]), 32'hF);
    chk("rst_ss_b", 32'(ss_v[1]), 32'hF);
    chk("rst_dout_a", 32'(dout_v[0]), 32'd0);
    chk("rst_dout_b", 32'(dout_v[1]), 32'd0);
    rst = 1'b0;

    // Mode 0 loopback on slave 0.
    launch(0, 1'b0, 1'b0, 2'd0, 8'hA5, 1'b1, 8'h00, t0);
    drain();
    chk("ss_after", 32'(ss_v[0]), 32'hF);

    // Modes 1, 2 and 3 against a slave returning 0x3C.
    for (int m = 1; m < 4; m++) begin
      launch(0, 1'(m >> 1), 1'(m & 1), 2'($urandom_range(0, 3)), W'($urandom), 1'b0, 8'h3C, t0);
      drain();
    end

    // Slave 2 only.
    launch(0, 1'b0, 1'b1, 2'd2, W'($urandom), 1'b0, W'($urandom), t0);
    drain();

    for (int n = 0; n < 6; n++) rand_frame(0);

    // Starts at edge 10 and edge 76 are ignored. The start held into edge 77 is accepted.
    d1 = W'($urandom); d2 = W'($urandom); r1 = W'($urandom); r2 = W'($urandom);
    launch(0, 1'b1, 1'b0, 2'd1, d1, 1'b0, r1, t0);
    while (cyc < t0 + 9) @(negedge clk);
    start_v[0] = 1'b1; din_v[0] = ~d1; sel_v[0] = 2'd3; cpha_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0; din_v[0] = d1; sel_v[0] = 2'd1; cpha_v[0] = 1'b0;
    while (cyc < t0 + 75) @(negedge clk);
    start_v[0] = 1'b1; din_v[0] = d2; slv_reply[0] = r2;
    @(negedge clk);
    sbq.push_back(make_exp(0, 1'b1, 2'd1, d2, 1'b0, r2, cyc + 1));
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("restart_busy", 32'(busy_v[0]), 32'd1);
    drain();

    // Asynchronous reset in the middle of a frame.
    launch(0, 1'b1, 1'b1, 2'd3, W'($urandom), 1'b0, W'($urandom), t0);
    while (cyc < t0 + 29) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_sclk", 32'(sclk_v[0]), 32'd0);
    chk("midrst_ss", 32'(ss_v[0]), 32'hF);
    chk("midrst_busy", 32'(busy_v[0]), 32'd0);
    chk("midrst_done", 32'(done_v[0]), 32'd0);
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    rand_frame(0);

    // Second instance: out-of-range select, LSB-first single-bit word, then random frames.
    launch(1, 1'b0, 1'b0, 2'd3, W'($urandom), 1'b0, W'($urandom), t0);
    drain();
    launch(1, 1'b0, 1'b0, 2'd0, 8'h01, 1'b0, W'($urandom), t0);
    drain();
    for (int n = 0; n < 8; n++) rand_frame(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
